pio_config_seq: RTL and testbench
=================================

PIO_CONFIG_SEQ -- requirements
Module: pio_config_seq

Interface
REQ-001 The block SHALL have parameter MAX_PLEN, default 32, meaning the maximum number of program instructions that can be loaded.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a single-cycle request to begin the configuration sequence.
REQ-005 The block SHALL have port stop, input, 1, a request to disable the running machine.
REQ-006 The block SHALL have ports cfg_plen input 6, cfg_div input 24, cfg_pin_grps input 32, cfg_sideset input 5 and cfg_mindex input 2, all latched when start is accepted.
REQ-007 The block SHALL have port prog_addr, output, 5, the program memory read address.
REQ-008 The block SHALL have port prog_data, input, 16, the program memory read data, valid one cycle after prog_addr.
REQ-009 The block SHALL have ports s_data input 32, s_valid input 1 and s_ready output 1, forming the TX word stream to be pushed into the PIO.
REQ-010 The block SHALL have ports action output 4, din output 32, index output 5 and mindex output 2, the PIO command bus.
REQ-011 The block SHALL have port full, input, 4, the per-machine TX FIFO full flags from the PIO.
REQ-012 The block SHALL have outputs busy 1, running 1, done 1 and err 1.

Function
REQ-013 Action codes SHALL be NONE=0, INSTR=1, PEND=2, PUSH=4, GRPS=5, EN=6, DIV=7 and SIDES=8.
REQ-014 action, din, index and mindex SHALL all be registered, and each non-NONE action SHALL be asserted for exactly one cycle.
REQ-015 The state machine SHALL have the states IDLE, FETCH, INSTR, PEND, DIV, GRPS, SIDES, EN, RUN and STOP.
REQ-016 In IDLE, when start=1 and cfg_plen is in the range 1..MAX_PLEN, the block SHALL latch the cfg_* inputs, clear err, set i=0 and go to FETCH.
REQ-017 In IDLE, when start=1 and cfg_plen is 0 or greater than MAX_PLEN, the block SHALL set err=1 and stay in IDLE.
REQ-018 In FETCH, the block SHALL drive prog_addr=i with action=NONE, then go to INSTR.
REQ-019 In INSTR, the block SHALL drive action=INSTR, index=i and din={16'b0,prog_data}. It SHALL then go to FETCH with i+1 if i<plen-1, otherwise to PEND.
REQ-020 Loading the program SHALL therefore take exactly 2*plen cycles.
REQ-021 In PEND, the block SHALL drive din=plen-1.
REQ-022 In DIV, the block SHALL drive din={8'b0,div}.
REQ-023 In GRPS, the block SHALL drive din=pin_grps.
REQ-024 In SIDES, the block SHALL drive din={27'b0,sideset}.
REQ-025 In EN, the block SHALL drive din=1<<mindex and pulse done for one cycle, then go to RUN.
REQ-026 The states PEND, DIV, GRPS, SIDES and EN SHALL each last exactly one cycle, in that order.
REQ-027 mindex SHALL equal the latched cfg_mindex from start until the block returns to IDLE.
REQ-028 In RUN, s_ready SHALL be 1 only when full[mindex]=0 and no PUSH was issued in the previous cycle. This limits the block to at most one PUSH per 2 cycles, which covers the one-cycle staleness of full.
REQ-029 When s_valid and s_ready are both 1, the next cycle SHALL carry action=PUSH with din=s_data.
REQ-030 In RUN, stop=1 SHALL take priority over a word accept in the same cycle; s_ready SHALL be 0 in that cycle and the block SHALL go to STOP.
REQ-031 In STOP, the block SHALL drive action=EN with din=0 for one cycle, then go to IDLE.
REQ-032 A stop asserted outside RUN SHALL be ignored.
REQ-033 A start asserted outside IDLE SHALL be ignored, and the latched configuration SHALL NOT change.
REQ-034 busy SHALL be 1 in every state except IDLE, and running SHALL be 1 only in RUN.
REQ-035 When the machine is not driving an action, action SHALL be NONE and din SHALL hold 0.

Reset
REQ-036 When reset=1, the next edge SHALL force the state to IDLE.
REQ-037 When reset=1, the next edge SHALL set action=NONE, din=0, index=0, mindex=0, prog_addr=0 and i=0.
REQ-038 When reset=1, the next edge SHALL clear s_ready, busy, running, done and err.
REQ-039 A reset applied mid-sequence or mid-RUN SHALL abort the sequence without emitting any further action.

Verification
REQ-040 Full configure: plen=7, div=0x000280, pin_grps=0x20000000, sideset=1, mindex=0, program 7 words -> 7 INSTR cycles with index 0..6 and the correct din. These SHALL be followed by PEND din=6, DIV din=0x280, GRPS din=0x20000000, SIDES din=1, EN din=1, with a done pulse and RUN reached 19 cycles after start.
REQ-041 Stream: in RUN with full=0, send words 2 and 4 back-to-back with s_valid held high -> PUSH din=2 then PUSH din=4, separated by one NONE cycle.
REQ-042 Backpressure: raise full[mindex]=1 in RUN -> s_ready=0 and no PUSH is issued; lower full -> the pending word is pushed exactly once.
REQ-043 Stop: stop and s_valid asserted in the same RUN cycle -> no PUSH, EN din=0, then IDLE with busy=0.
REQ-044 Error/ignore: start with plen=0 -> err=1 and no action; start asserted during FETCH -> the sequence is unchanged.
REQ-045 Reset mid-load: assert reset at INSTR index 3 -> action=NONE next cycle, IDLE, and all outputs at their reset values.

Source files
------------

// File: rtl/pio_config_seq.sv
// PIO configuration sequencer: loads a program into one state machine, programs its
// wrap/clock/pins/side-set, enables it, then streams TX words until stopped.
module pio_config_seq #(
  parameter int unsigned MAX_PLEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [5:0]  cfg_plen,
  input  logic [23:0] cfg_div,
  input  logic [31:0] cfg_pin_grps,
  input  logic [4:0]  cfg_sideset,
  input  logic [1:0]  cfg_mindex,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [3:0]  action,
  output logic [31:0] din,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  input  logic [3:0]  full,
  output logic        busy,
  output logic        running,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 6;

  localparam logic [3:0] ACT_NONE  = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PEND  = 4'd2;
  localparam logic [3:0] ACT_PUSH  = 4'd4;
  localparam logic [3:0] ACT_GRPS  = 4'd5;
  localparam logic [3:0] ACT_EN    = 4'd6;
  localparam logic [3:0] ACT_DIV   = 4'd7;
  localparam logic [3:0] ACT_SIDES = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_INSTR, ST_PEND, ST_DIV,
    ST_GRPS, ST_SIDES, ST_EN, ST_RUN, ST_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [PW-1:0] plen_q, plen_d;
  logic [23:0]   div_q, div_d;
  logic [DW-1:0] grps_q, grps_d;
  logic [4:0]    side_q, side_d;
  logic [3:0]    action_q, action_d;
  logic [DW-1:0] din_q, din_d;
  logic [AW-1:0] index_q, index_d;
  logic [1:0]    mindex_q, mindex_d;
  logic [AW-1:0] prog_addr_q, prog_addr_d;
  logic          busy_q, busy_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          plen_ok;
  logic          last_instr;

  assign plen_ok    = (cfg_plen != '0) && (32'(cfg_plen) <= MAX_PLEN);
  assign last_instr = !({1'b0, i_q} < (plen_q - PW'(1)));

  // Ready is same-cycle so a stop can veto an accept; the PUSH gap covers stale full.
  assign s_ready = (state_q == ST_RUN) && !stop && !full[mindex_q] && (action_q != ACT_PUSH);

  // Next-state and registered-output decode; command bus trails the state by one cycle
  // so INSTR can capture prog_data, which returns one cycle after prog_addr.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    plen_d      = plen_q;
    div_d       = div_q;
    grps_d      = grps_q;
    side_d      = side_q;
    action_d    = ACT_NONE;
    din_d       = '0;
    index_d     = index_q;
    mindex_d    = mindex_q;
    prog_addr_d = prog_addr_q;
    done_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start && plen_ok) begin
          plen_d   = cfg_plen;
          div_d    = cfg_div;
          grps_d   = cfg_pin_grps;
          side_d   = cfg_sideset;
          mindex_d = cfg_mindex;
          err_d    = 1'b0;
          i_d      = '0;
          state_d  = ST_FETCH;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_INSTR;
      ST_INSTR: begin
        action_d = ACT_INSTR;
        index_d  = i_q;
        din_d    = {16'h0, prog_data};
        if (last_instr) begin
          state_d = ST_PEND;
        end else begin
          i_d     = i_q + AW'(1);
          state_d = ST_FETCH;
        end
      end
      ST_PEND: begin
        action_d = ACT_PEND;
        din_d    = DW'(plen_q - PW'(1));
        state_d  = ST_DIV;
      end
      ST_DIV: begin
        action_d = ACT_DIV;
        din_d    = {8'h0, div_q};
        state_d  = ST_GRPS;
      end
      ST_GRPS: begin
        action_d = ACT_GRPS;
        din_d    = grps_q;
        state_d  = ST_SIDES;
      end
      ST_SIDES: begin
        action_d = ACT_SIDES;
        din_d    = {27'h0, side_q};
        state_d  = ST_EN;
      end
      ST_EN: begin
        action_d = ACT_EN;
        din_d    = DW'(1) << mindex_q;
        done_d   = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_STOP;
        end else if (s_valid && s_ready) begin
          action_d = ACT_PUSH;
          din_d    = s_data;
        end
      end
      ST_STOP: begin
        action_d = ACT_EN;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_FETCH) begin
      prog_addr_d = i_d;
    end
    busy_d    = (state_d != ST_IDLE);
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      plen_q      <= '0;
      div_q       <= '0;
      grps_q      <= '0;
      side_q      <= '0;
      action_q    <= ACT_NONE;
      din_q       <= '0;
      index_q     <= '0;
      mindex_q    <= '0;
      prog_addr_q <= '0;
      busy_q      <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      plen_q      <= plen_d;
      div_q       <= div_d;
      grps_q      <= grps_d;
      side_q      <= side_d;
      action_q    <= action_d;
      din_q       <= din_d;
      index_q     <= index_d;
      mindex_q    <= mindex_d;
      prog_addr_q <= prog_addr_d;
      busy_q      <= busy_d;
      running_q   <= running_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign action    = action_q;
  assign din       = din_q;
  assign index     = index_q;
  assign mindex    = mindex_q;
  assign prog_addr = prog_addr_q;
  assign busy      = busy_q;
  assign running   = running_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pio_config_seq.sv
// Bench for pio_config_seq: expected command streams are built from the sequencing rules
// (2 cycles per instruction, fixed trailer, one PUSH per accepted word) with a small memory model.
module tb_pio_config_seq;

  localparam int unsigned MAX_PLEN = 32;
  localparam logic [3:0] A_NONE  = 4'd0;
  localparam logic [3:0] A_INSTR = 4'd1;
  localparam logic [3:0] A_PEND  = 4'd2;
  localparam logic [3:0] A_PUSH  = 4'd4;
  localparam logic [3:0] A_GRPS  = 4'd5;
  localparam logic [3:0] A_EN    = 4'd6;
  localparam logic [3:0] A_DIV   = 4'd7;
  localparam logic [3:0] A_SIDES = 4'd8;

  logic        clk = 1'b0;
  logic        reset, start, stop, s_valid;
  logic [5:0]  cfg_plen;
  logic [23:0] cfg_div;
  logic [31:0] cfg_pin_grps, s_data, din;
  logic [4:0]  cfg_sideset, prog_addr, index;
  logic [1:0]  cfg_mindex, mindex;
  logic [15:0] prog_data;
  logic        s_ready, busy, running, done, err;
  logic [3:0]  action, full;
  logic [15:0] prog_mem [32];

  int errors = 0;
  int checks = 0;
  logic [1:0] cur_mi;

  always #5 clk = ~clk;

  // Program memory: synchronous read, data one cycle after the address.
  always @(posedge clk) prog_data <= prog_mem[prog_addr];

  pio_config_seq #(.MAX_PLEN(MAX_PLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_plen(cfg_plen), .cfg_div(cfg_div), .cfg_pin_grps(cfg_pin_grps),
    .cfg_sideset(cfg_sideset), .cfg_mindex(cfg_mindex),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .action(action), .din(din), .index(index), .mindex(mindex),
    .full(full), .busy(busy), .running(running), .done(done), .err(err)
  );

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0; full = '0;
    cfg_plen = '0; cfg_div = '0; cfg_pin_grps = '0; cfg_sideset = '0; cfg_mindex = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({action, din, index, mindex, prog_addr} !== 48'h0) begin
      errors++; $display("FAIL reset_bus: got act=%0d din=%h idx=%0d mi=%0d addr=%0d expected all 0",
                         action, din, index, mindex, prog_addr);
    end
    checks++;
    if ({s_ready, busy, running, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {s_ready, busy, running, done, err});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({action, busy} !== {A_NONE, 1'b0}) begin
      errors++; $display("FAIL reset_idle: got act=%0d busy=%b expected act=0 busy=0", action, busy);
    end
  endtask

  task automatic test_error(input int p);
    @(negedge clk);
    cfg_plen = 6'(p); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({err, busy, action} !== {1'b1, 1'b0, A_NONE}) begin
      errors++; $display("FAIL bad_plen_%0d: got err=%b busy=%b act=%0d expected err=1 busy=0 act=0",
                         p, err, busy, action);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, action, din} !== {1'b0, A_NONE, 32'h0}) begin
        errors++; $display("FAIL bad_plen_quiet: got busy=%b act=%0d din=%h expected 0 0 0", busy, action, din);
      end
    end
  endtask

  task automatic test_configure(input int p, input logic [23:0] dv, input logic [31:0] gp,
                                input logic [4:0] sd, input logic [1:0] mi, input bit inject);
    logic [3:0]  ea;
    logic [31:0] ed;
    logic        edone;
    int          last;
    last = 2 * p + 5;
    cur_mi = mi;
    for (int k = 0; k < 32; k++) prog_mem[k] = 16'($urandom);
    @(negedge clk);
    cfg_plen = 6'(p); cfg_div = dv; cfg_pin_grps = gp; cfg_sideset = sd; cfg_mindex = mi; start = 1'b1;
    @(negedge clk);
    if (inject) begin
      // a second start (and a stray stop) during FETCH must change nothing
      cfg_plen = 6'($urandom_range(1, MAX_PLEN)); cfg_div = 24'($urandom);
      cfg_pin_grps = $urandom; cfg_sideset = 5'($urandom); cfg_mindex = 2'($urandom); stop = 1'b1;
    end else begin
      start = 1'b0;
    end
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      ea = A_NONE; ed = '0; edone = 1'b0;
      if (c <= 2 * p) begin
        if (c % 2 == 0) begin ea = A_INSTR; ed = {16'h0, prog_mem[c / 2 - 1]}; end
      end else if (c == 2 * p + 1) begin ea = A_PEND;  ed = 32'(p - 1);
      end else if (c == 2 * p + 2) begin ea = A_DIV;   ed = {8'h0, dv};
      end else if (c == 2 * p + 3) begin ea = A_GRPS;  ed = gp;
      end else if (c == 2 * p + 4) begin ea = A_SIDES; ed = {27'h0, sd};
      end else begin ea = A_EN; ed = 32'h1 << mi; edone = 1'b1; end
      checks++;
      if ({action, din, done} !== {ea, ed, edone}) begin
        errors++; $display("FAIL cfg_bus p=%0d c=%0d: got act=%0d din=%h done=%b expected act=%0d din=%h done=%b",
                           p, c, action, din, done, ea, ed, edone);
      end
      if (ea == A_INSTR) begin
        checks++;
        if (index !== 5'(c / 2 - 1)) begin
          errors++; $display("FAIL cfg_index c=%0d: got %0d expected %0d", c, index, c / 2 - 1);
        end
      end
      checks++;
      if ({busy, running, err, mindex} !== {1'b1, c == last, 1'b0, mi}) begin
        errors++; $display("FAIL cfg_status c=%0d: got busy=%b run=%b err=%b mi=%0d expected 1 %b 0 %0d",
                           c, busy, running, err, mindex, c == last, mi);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    full = 4'h0; s_valid = 1'b1; s_data = 32'd2;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b expected 1", s_ready); end
    @(negedge clk);
    checks++;
    if ({action, din} !== {A_PUSH, 32'd2}) begin
      errors++; $display("FAIL b2b_push2: got act=%0d din=%h expected act=4 din=2", action, din);
    end
    s_data = 32'd4;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_gap_ready: got %b expected 0", s_ready); end
    @(negedge clk);
    checks++;
    if ({action, din, s_ready} !== {A_NONE, 32'h0, 1'b1}) begin
      errors++; $display("FAIL b2b_gap: got act=%0d din=%h rdy=%b expected act=0 din=0 rdy=1", action, din, s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if ({action, din} !== {A_PUSH, 32'd4}) begin
      errors++; $display("FAIL b2b_push4: got act=%0d din=%h expected act=4 din=4", action, din);
    end
    @(negedge clk);
    checks++;
    if (action !== A_NONE) begin errors++; $display("FAIL b2b_tail: got act=%0d expected 0", action); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    w = $urandom;
    @(negedge clk);
    full = 4'($urandom) | (4'h1 << cur_mi); s_valid = 1'b1; s_data = w;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready k=%0d: got %b expected 0", k, s_ready); end
      @(negedge clk);
      checks++;
      if (action !== A_NONE) begin errors++; $display("FAIL bp_nopush k=%0d: got act=%0d expected 0", k, action); end
    end
    full = ~(4'h1 << cur_mi);
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", s_ready); end
    @(negedge clk);
    s_valid = 1'b0; full = 4'h0;
    checks++;
    if ({action, din} !== {A_PUSH, w}) begin
      errors++; $display("FAIL bp_push: got act=%0d din=%h expected act=4 din=%h", action, din, w);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (action !== A_NONE) begin errors++; $display("FAIL bp_once k=%0d: got act=%0d expected 0", k, action); end
    end
  endtask

  task automatic test_stream_random();
    logic [31:0] q[$];
    logic        pend, exp_r;
    logic [31:0] pd;
    int          cyc;
    for (int k = 0; k < 12; k++) q.push_back($urandom);
    pend = 1'b0; pd = '0; s_valid = 1'b0;
    for (cyc = 0; cyc < 400 && (q.size() > 0 || pend); cyc++) begin
      @(negedge clk);
      checks++;
      if (pend ? ({action, din} !== {A_PUSH, pd}) : (action !== A_NONE)) begin
        errors++; $display("FAIL stream_bus cyc=%0d: got act=%0d din=%h expected push=%b din=%h",
                           cyc, action, din, pend, pd);
      end
      full = (cyc >= 200) ? 4'h0 : 4'($urandom);
      if (q.size() > 0) begin
        if (!s_valid) s_valid = ($urandom_range(0, 3) != 0);
        s_data = q[0];
      end else begin
        s_valid = 1'b0;
      end
      #1;
      exp_r = !full[cur_mi] && !pend;
      checks++;
      if (s_ready !== exp_r) begin
        errors++; $display("FAIL stream_ready cyc=%0d: got %b expected %b", cyc, s_ready, exp_r);
      end
      pend = s_valid && exp_r;
      if (pend) pd = q.pop_front();
    end
    s_valid = 1'b0; full = 4'h0;
    checks++;
    if (q.size() > 0 || pend) begin
      errors++; $display("FAIL stream_drain: got %0d words left expected 0", q.size());
    end
  endtask

  task automatic test_stop();
    @(negedge clk);
    stop = 1'b1; s_valid = 1'b1; s_data = $urandom; full = 4'h0;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL stop_ready: got %b expected 0", s_ready); end
    @(negedge clk);
    stop = 1'b0; s_valid = 1'b0;
    checks++;
    if ({action, busy, running, mindex} !== {A_NONE, 1'b1, 1'b0, cur_mi}) begin
      errors++; $display("FAIL stop_state: got act=%0d busy=%b run=%b mi=%0d expected 0 1 0 %0d",
                         action, busy, running, mindex, cur_mi);
    end
    @(negedge clk);
    checks++;
    if ({action, din, busy} !== {A_EN, 32'h0, 1'b0}) begin
      errors++; $display("FAIL stop_disable: got act=%0d din=%h busy=%b expected act=6 din=0 busy=0",
                         action, din, busy);
    end
    @(negedge clk);
    checks++;
    if ({action, din, busy} !== {A_NONE, 32'h0, 1'b0}) begin
      errors++; $display("FAIL stop_idle: got act=%0d din=%h busy=%b expected 0 0 0", action, din, busy);
    end
  endtask

  task automatic test_reset_mid_load();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 32; k++) prog_mem[k] = 16'($urandom);
    @(negedge clk);
    cfg_plen = 6'd7; cfg_div = 24'($urandom); cfg_pin_grps = $urandom; cfg_sideset = 5'd3;
    cfg_mindex = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (action === A_INSTR && index === 5'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midload_reach: got no INSTR index 3 expected one"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({action, din, index, mindex, prog_addr} !== 48'h0) begin
      errors++; $display("FAIL midload_bus: got act=%0d din=%h idx=%0d mi=%0d addr=%0d expected all 0",
                         action, din, index, mindex, prog_addr);
    end
    checks++;
    if ({s_ready, busy, running, done, err} !== 5'b0) begin
      errors++; $display("FAIL midload_flags: got %b expected 00000", {s_ready, busy, running, done, err});
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({action, busy} !== {A_NONE, 1'b0}) begin
        errors++; $display("FAIL midload_quiet k=%0d: got act=%0d busy=%b expected 0 0", k, action, busy);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    test_configure(1, 24'h000100, 32'h0000_00ff, 5'd0, 2'd3, 1'b0);
    @(negedge clk);
    s_valid = 1'b1; s_data = $urandom; full = 4'h0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; s_valid = 1'b0;
    checks++;
    if ({action, busy, running} !== {A_NONE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midrun_reset: got act=%0d busy=%b run=%b expected 0 0 0", action, busy, running);
    end
    @(negedge clk);
    checks++;
    if (action !== A_NONE) begin errors++; $display("FAIL midrun_quiet: got act=%0d expected 0", action); end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) prog_mem[k] = '0;
    cur_mi = '0;
    test_reset();
    test_error(0);
    test_error(MAX_PLEN + 1);
    test_configure(7, 24'h000280, 32'h2000_0000, 5'd1, 2'd0, 1'b0);
    test_back_to_back();
    test_backpressure();
    test_stop();
    test_configure($urandom_range(2, MAX_PLEN), 24'($urandom), $urandom, 5'($urandom), 2'($urandom), 1'b1);
    test_stream_random();
    test_backpressure();
    test_stop();
    test_configure(MAX_PLEN, 24'($urandom), $urandom, 5'($urandom), 2'd3, 1'b0);
    test_back_to_back();
    test_stop();
    test_reset_mid_load();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
